// File: rtl/sev_seg_pkg.sv
// rtl/sev_seg_pkg.sv - shared constants and hex decode for the seven-segment scanner
package sev_seg_pkg;

  // All segments off (active low {a..g})
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Hex-to-segment table, active low {a,b,c,d,e,f,g}; entry 15 first
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h38, 7'h30, 7'h42, 7'h31,   // F E d C
    7'h60, 7'h08, 7'h0C, 7'h00,   // b A 9 8
    7'h0F, 7'h20, 7'h24, 7'h4C,   // 7 6 5 4
    7'h06, 7'h12, 7'h4F, 7'h01    // 3 2 1 0
  };

  function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/sev_seg_prescaler.sv
// rtl/sev_seg_prescaler.sv - dwell counter issuing a one-cycle tick per digit slot
module sev_seg_prescaler #(
  parameter int DWELL = 5
) (
  input  logic CLK,
  input  logic RST_N,
  output logic tick
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // Count 0..DWELL-1 and wrap; the tick marks the wrap cycle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sev_seg_scanner.sv
// rtl/sev_seg_scanner.sv - multiplexed N-digit common-anode seven-segment scanner
module sev_seg_scanner
  import sev_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_FREQ_HZ  = 100_000_000,
  parameter int REFRESH_HZ   = 1000,
  parameter int PWM_BITS     = 4,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [4*NUM_DIGITS-1:0] HEX,
  input  logic [NUM_DIGITS-1:0]   DP_IN,
  input  logic [NUM_DIGITS-1:0]   DIGIT_EN,
  input  logic                    LZ_SUPPRESS,
  input  logic [PWM_BITS-1:0]     BRIGHTNESS,
  output logic [7:0]              CATHODES,
  output logic [NUM_DIGITS-1:0]   ANODES
);

  localparam int DWELL = CLK_FREQ_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int IW    = $clog2(NUM_DIGITS);
  localparam int GW    = $clog2(GUARD_CYCLES + 2);
  localparam logic [IW-1:0]       LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [GW-1:0]       GUARD_LD = GW'(GUARD_CYCLES);
  localparam logic [PWM_BITS-1:0] PWM_FULL = '1;

  if (DWELL < GUARD_CYCLES + 2) begin : g_dwell_check
    $error("sev_seg_scanner: dwell too short for the guard interval");
  end

  logic                    tick;
  logic                    frame_load;
  logic                    first_q;
  logic [IW-1:0]           digit_idx;
  logic [PWM_BITS-1:0]     pwm_cnt;
  logic [GW-1:0]           guard_cnt;
  logic [4*NUM_DIGITS-1:0] hex_f;
  logic [NUM_DIGITS-1:0]   dp_f;
  logic [NUM_DIGITS-1:0]   en_f;
  logic                    lz_f;
  logic [NUM_DIGITS-1:0]   suppress;
  logic [3:0]              nibble;
  logic                    blank;
  logic                    anode_on;
  logic [7:0]              cath_nxt;
  logic [NUM_DIGITS-1:0]   anode_nxt;

  sev_seg_prescaler #(
    .DWELL(DWELL)
  ) u_prescaler (
    .CLK  (CLK),
    .RST_N(RST_N),
    .tick (tick)
  );

  // Capture a new frame at the start of each scan and right after reset release
  assign frame_load = first_q | (tick & (digit_idx == LAST_IDX));

  // Scan index, guard countdown, free-running PWM counter and frame capture
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      first_q   <= 1'b1;
      digit_idx <= '0;
      pwm_cnt   <= '0;
      guard_cnt <= '0;
      hex_f     <= '0;
      dp_f      <= '0;
      en_f      <= '0;
      lz_f      <= 1'b0;
    end else begin
      first_q <= 1'b0;
      pwm_cnt <= pwm_cnt + 1'b1;
      if (tick) begin
        digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
        guard_cnt <= GUARD_LD;
      end else if (guard_cnt != '0) begin
        guard_cnt <= guard_cnt - 1'b1;
      end
      if (frame_load) begin
        hex_f <= HEX;
        dp_f  <= DP_IN;
        en_f  <= DIGIT_EN;
        lz_f  <= LZ_SUPPRESS;
      end
    end
  end

  // Leading-zero mask: digit k blanks when it and every digit to its left are zero
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    suppress = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero    = all_zero & (hex_f[4*k +: 4] == 4'h0);
      suppress[k] = lz_f & all_zero & (k != 0);
    end
  end

  // Next cathode/anode pattern for the current digit, PWM phase and guard state
  always_comb begin
    nibble    = hex_f[{digit_idx, 2'b00} +: 4];
    blank     = ~en_f[digit_idx] | suppress[digit_idx];
    cath_nxt  = {~dp_f[digit_idx], blank ? SEG_BLANK : seg7_decode(nibble)};
    anode_on  = (BRIGHTNESS == PWM_FULL) || (pwm_cnt < BRIGHTNESS);
    anode_nxt = '1;
    if ((guard_cnt == '0) && anode_on) begin
      anode_nxt[digit_idx] = 1'b0;
    end
  end

  // Registered pin drivers; reset forces everything dark at once
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      CATHODES <= 8'hFF;
      ANODES   <= '1;
    end else begin
      CATHODES <= cath_nxt;
      ANODES   <= anode_nxt;
    end
  end

endmodule

// File: tb/tb_sev_seg_scanner.sv
// tb/tb_sev_seg_scanner.sv - directed self-checking bench for sev_seg_scanner
module tb_sev_seg_scanner;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [15:0] HEX;
  logic [3:0]  DP_IN;
  logic [3:0]  DIGIT_EN;
  logic        LZ_SUPPRESS;
  logic [1:0]  BRIGHTNESS;
  logic [7:0]  CATHODES;
  logic [3:0]  ANODES;

  int checks = 0;
  int errors = 0;

  sev_seg_scanner #(
    .NUM_DIGITS  (4),
    .CLK_FREQ_HZ (1000),
    .REFRESH_HZ  (50),
    .PWM_BITS    (2),
    .GUARD_CYCLES(1)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .HEX        (HEX),
    .DP_IN      (DP_IN),
    .DIGIT_EN   (DIGIT_EN),
    .LZ_SUPPRESS(LZ_SUPPRESS),
    .BRIGHTNESS (BRIGHTNESS),
    .CATHODES   (CATHODES),
    .ANODES     (ANODES)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) until digit k is the one lit
  task automatic wait_anode(input int k);
    logic [3:0] want;
    int n;
    want = 4'hF;
    want[k[1:0]] = 1'b0;
    n = 0;
    while (ANODES !== want && n < 60) begin
      @(negedge CLK);
      n++;
    end
    if (ANODES !== want) check("wait_digit", {28'd0, ANODES}, {28'd0, want});
  endtask

  // Check digit k on its second lit cycle
  task automatic show_digit(input int k, input logic [7:0] exp_cath);
    logic [3:0] want;
    want = 4'hF;
    want[k[1:0]] = 1'b0;
    wait_anode(k);
    @(negedge CLK);
    check($sformatf("anode_d%0d", k), {28'd0, ANODES}, {28'd0, want});
    check($sformatf("cath_d%0d", k), {24'd0, CATHODES}, {24'd0, exp_cath});
  endtask

  // Skip to the first digit-0 slot of a frame captured after the caller's input change
  task automatic next_frame();
    wait_anode(2);
    wait_anode(0);
  endtask

  initial begin
    logic [3:0] last;
    int gap, bad, lows, nsw;

    RST_N = 1'b0;
    HEX = 16'h12AF;
    DP_IN = 4'h0;
    DIGIT_EN = 4'hF;
    LZ_SUPPRESS = 1'b0;
    BRIGHTNESS = 2'b11;
    repeat (3) @(negedge CLK);
    check("rst_anodes", {28'd0, ANODES}, 32'hF);
    check("rst_cathodes", {24'd0, CATHODES}, 32'hFF);

    // First frame after release
    RST_N = 1'b1;
    show_digit(0, 8'hB8);
    show_digit(1, 8'h88);
    show_digit(2, 8'h92);
    show_digit(3, 8'hCF);

    // Guard gaps and one-hot anodes over two frames
    last = 4'hF; gap = 0; bad = 0; nsw = 0;
    repeat (40) begin
      @(negedge CLK);
      if ($countones(~ANODES) > 1) bad++;
      if (ANODES == 4'hF) gap++;
      else begin
        if (last != 4'hF && ANODES != last) begin
          check("guard_gap", gap, 1);
          nsw++;
        end
        gap = 0;
        last = ANODES;
      end
    end
    check("one_hot", bad, 0);
    check("switch_count_ok", (nsw >= 6) ? 1 : 0, 1);

    // Frame coherence: change mid-scan while digit 2 is lit
    wait_anode(1);
    wait_anode(2);
    HEX = 16'h3456;
    show_digit(2, 8'h92);
    show_digit(3, 8'hCF);
    show_digit(0, 8'hA0);
    show_digit(1, 8'hA4);
    show_digit(2, 8'hCC);
    show_digit(3, 8'h86);

    // Leading-zero suppression
    HEX = 16'h0005;
    LZ_SUPPRESS = 1'b1;
    next_frame();
    show_digit(0, 8'hA4);
    show_digit(1, 8'hFF);
    show_digit(2, 8'hFF);
    show_digit(3, 8'hFF);

    HEX = 16'h0000;
    next_frame();
    show_digit(0, 8'h81);
    show_digit(1, 8'hFF);

    // Decimal point survives suppression
    HEX = 16'h0005;
    DP_IN = 4'b0010;
    next_frame();
    show_digit(0, 8'hA4);
    show_digit(1, 8'h7F);

    // Per-digit blanking
    HEX = 16'h12AF;
    DP_IN = 4'h0;
    LZ_SUPPRESS = 1'b0;
    DIGIT_EN = 4'b1011;
    next_frame();
    show_digit(2, 8'hFF);
    show_digit(3, 8'hCF);

    // PWM at brightness 1: one lit cycle per dwell
    BRIGHTNESS = 2'b01;
    repeat (3) @(negedge CLK);
    lows = 0; bad = 0;
    repeat (20) begin
      @(negedge CLK);
      if (ANODES != 4'hF) lows++;
      if ($countones(~ANODES) > 1) bad++;
    end
    check("pwm1_lit_cycles", lows, 4);
    check("pwm1_one_hot", bad, 0);

    // Brightness 0: always dark
    BRIGHTNESS = 2'b00;
    repeat (3) @(negedge CLK);
    lows = 0;
    repeat (20) begin
      @(negedge CLK);
      if (ANODES != 4'hF) lows++;
    end
    check("pwm0_lit_cycles", lows, 0);

    // Asynchronous reset between clock edges
    BRIGHTNESS = 2'b11;
    repeat (7) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    check("async_rst_anodes", {28'd0, ANODES}, 32'hF);
    check("async_rst_cathodes", {24'd0, CATHODES}, 32'hFF);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check("restart_digit0", {28'd0, ANODES}, 32'hE);
    show_digit(0, 8'hB8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sev_seg_scanner.md
Name: sev_seg_scanner

Overview:
Parametrised multiplexed seven-segment scanner for N common-anode digits. Generalises the fixed 4-digit hex driver with the following additions:
- per-digit decimal points and blanking
- leading-zero suppression
- PWM brightness control
- an anti-ghosting guard interval
- frame-coherent input capture, so a value never tears mid-scan

Sits between the OTTER MMIO display register and the board pins (CATHODES/ANODES).

Parameters:
NUM_DIGITS, 4, digits scanned (2..8)
CLK_FREQ_HZ, 100_000_000, CLK frequency
REFRESH_HZ, 1000, full-frame refresh rate
PWM_BITS, 4, brightness resolution
GUARD_CYCLES, 16, all-anodes-off cycles after each digit switch

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
HEX  in  4*NUM_DIGITS  nibble k drives digit k (digit 0 = rightmost)
DP_IN  in  NUM_DIGITS  1 = light decimal point of digit k
DIGIT_EN  in  NUM_DIGITS  0 = force digit k blank
LZ_SUPPRESS  in  1  1 = blank leading zero digits
BRIGHTNESS  in  PWM_BITS  0 = dark, all-ones = full on
CATHODES  out  8  {dp,a,b,c,d,e,f,g}, active low
ANODES  out  NUM_DIGITS  one-hot-low digit select, active low

Behaviour:
- Reset (async assert, sync release):
  - outputs: ANODES all 1, CATHODES 8'hFF
  - internal: digit index 0, prescaler 0, PWM counter 0, guard counter 0
  - frame registers: 0 (DIGIT_EN frame copy = 0, so blank until first capture)
- Prescaler:
  - DWELL = CLK_FREQ_HZ/(REFRESH_HZ*NUM_DIGITS).
  - Counts 0..DWELL-1, then wraps; a one-cycle tick is issued at the wrap.
  - Elaboration $error if DWELL < GUARD_CYCLES+2.
- Digit index:
  - Advances on tick; wraps NUM_DIGITS-1 -> 0.
- Frame capture:
  - HEX, DP_IN, DIGIT_EN and LZ_SUPPRESS are registered on the tick that wraps the index to 0, and on the first cycle after reset release.
  - Input changes take effect only at the next frame start.
  - BRIGHTNESS is not framed; it is sampled live.
- Leading-zero suppression (from frame copy):
  - Digit k is suppressed when LZ is set and all nibbles k..N-1 are 0.
  - Digit 0 is never suppressed, so value 0 shows "0".
  - A DP on a suppressed digit is still lit.
- Segment value:
  - digit blank (DIGIT_EN=0 or suppressed) -> segments 7'h7F
  - otherwise -> hex decode of nibble
  - dp bit = ~DP_IN[k]
- Guard:
  - For GUARD_CYCLES cycles starting the cycle after each tick, ANODES are all 1.
  - CATHODES are updated to the new digit during the guard.
- PWM:
  - Free-running PWM_BITS counter, incremented every CLK.
  - Anode on iff (BRIGHTNESS == all-ones) or (pwm_cnt < BRIGHTNESS).
  - BRIGHTNESS = 0 means ANODES stay all 1.
- Output timing:
  - ANODES and CATHODES are registered, one CLK after the internal index/PWM/guard state.
  - ANODES has at most one bit low at any time.
- Simultaneous events: the frame-capture tick and the guard start in the same cycle; capture uses inputs present on that cycle.
- Reset mid-scan: outputs return to all-off immediately (asynchronously).

Decomposition:
- Package sev_seg_pkg:
  - SEG_BLANK = 7'h7F
  - 16-entry hex-to-segment constant table (active-low {a..g}); 0=7'h01, 1=4F, 2=12, 3=06, 4=4C, 5=24, 6=20, 7=0F, 8=00, 9=0C, A=08, b=60, C=31, d=42, E=30, F=38
  - function seg7_decode(nibble)
- Sub-module sev_seg_prescaler: parametrised counter producing the tick.
- Decode, suppression, PWM and guard logic live in the top.

Test Plan:
Common bench parameters: CLK_FREQ_HZ=1000, REFRESH_HZ=50, NUM_DIGITS=4 (DWELL=5), GUARD_CYCLES=1, PWM_BITS=2, BRIGHTNESS=2'b11.
- Reset and first frame: hold RST_N=0 -> ANODES=4'hF and CATHODES=8'hFF. Then release with HEX=16'h12AF, DIGIT_EN=4'hF. Required over one frame, per digit after its guard cycle:
  - digit 0: ANODES=1110, CATHODES=8'hB8
  - digit 1: ANODES=1101, CATHODES=8'h88
  - digit 2: ANODES=1011, CATHODES=8'h92
  - digit 3: ANODES=0111, CATHODES=8'hCF
- Guard/ghosting: every digit switch -> exactly 1 cycle with ANODES=4'hF; never two anodes low.
- Frame coherence: change HEX 16'h12AF->16'h3456 while digit 2 is active -> digits 2 and 3 still show 2 and 1; the next frame shows 6,5,4,3 (8'hA0, 8'hA4, 8'hCC, 8'h86).
- LZ/DP/blank cases:
  - HEX=16'h0005, LZ=1 -> digits 3,2,1 give CATHODES=8'hFF; digit 0 gives 8'hA4
  - HEX=16'h0000, LZ=1 -> digit 0 gives 8'h81
  - DP_IN=4'b0010 with digit 1 suppressed -> digit 1 gives 8'h7F
  - DIGIT_EN=4'b1011 -> digit 2 gives 8'hFF
- PWM: BRIGHTNESS=1 -> active anode low 1 of every 4 cycles within the dwell. BRIGHTNESS=0 -> ANODES never leave 4'hF.
- Async reset mid-dwell: assert RST_N low between clock edges -> outputs go to ANODES=4'hF, CATHODES=8'hFF without a clock edge. After release, the scan restarts at digit 0.
